// File: rtl/led_scan_driver.sv
// led_scan_driver: time-multiplexed scan engine for two 4-digit 7-segment
// displays. Display 0 shows nibbles 3..0 and display 1 shows nibbles 7..4.
// A new value is held in a pending register until the frame boundary, so a
// single frame never mixes two values.
// Optional feature: define LED_LZB_EN to blank leading zeros across all 8 digits.
//
// state | meaning
// BLANK | dead time at the start of a slot: anodes off, segments settling
// DRIVE | anode of the current digit on (when en = 1)

module led_scan_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wr_en,
  input  logic [31:0] num_i,
  input  logic [7:0]  dp_i,
  output logic        busy,
  output logic [7:0]  seg0,
  output logic [3:0]  an0,
  output logic [7:0]  seg1,
  output logic [3:0]  an1
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [1:0]    idx_nxt;
  logic [31:0]   disp, pend, disp_nxt;
  logic [7:0]    disp_dp, pend_dp, disp_dp_nxt;
  logic          blank_end, slot_end, frame_end;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Segment pattern for digit k (0..7) of the 32-bit value, dp included.
  function automatic logic [7:0] digit_seg(input logic [31:0] v, input logic [7:0] dp,
                                           input logic [2:0] k);
    logic [31:0] upper;
    logic [7:0]  s;
    upper = v >> {k, 2'b00};
    s     = {dp[k], hex7(upper[3:0])};
`ifdef LED_LZB_EN
    if ((k != 3'd0) && (upper == 32'h0)) s = {dp[k], 7'h00};
`endif
    return s;
  endfunction

  // Slot/frame timing strobes and the value disp takes on the next edge.
  always_comb begin
    blank_end   = (state == BLANK) && (presc == PW'(BLANK_CYC - 1));
    slot_end    = (state == DRIVE) && (presc == PW'(SCAN_DIV - 1));
    frame_end   = slot_end && (idx == 2'd3);
    idx_nxt     = idx + 2'd1;
    disp_nxt    = disp;
    disp_dp_nxt = disp_dp;
    if (frame_end) begin
      if (wr_en) begin
        disp_nxt    = num_i;
        disp_dp_nxt = dp_i;
      end else if (busy) begin
        disp_nxt    = pend;
        disp_dp_nxt = pend_dp;
      end
    end
  end

  // Write path: capture into pend, commit to disp only on the frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      pend    <= 32'h0;
      pend_dp <= 8'h0;
      disp    <= 32'h0;
      disp_dp <= 8'h0;
    end else begin
      disp    <= disp_nxt;
      disp_dp <= disp_dp_nxt;
      if (wr_en) begin
        pend    <= num_i;
        pend_dp <= dp_i;
      end
      if (frame_end)  busy <= 1'b0;
      else if (wr_en) busy <= 1'b1;
    end
  end

  // Slot FSM with registered segment/anode outputs; outputs move only on
  // state transitions. Segments for the next digit are loaded entering BLANK
  // so they are stable before the anode turns on.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BLANK;
      presc <= '0;
      idx   <= 2'd0;
      seg0  <= 8'h0;
      seg1  <= 8'h0;
      an0   <= 4'h0;
      an1   <= 4'h0;
    end else begin
      case (state)
        BLANK: begin
          presc <= presc + PW'(1);
          if (blank_end) begin
            state <= DRIVE;
            an0   <= en ? (4'b0001 << idx) : 4'h0;
            an1   <= en ? (4'b0001 << idx) : 4'h0;
            seg0  <= digit_seg(disp, disp_dp, {1'b0, idx});
            seg1  <= digit_seg(disp, disp_dp, {1'b1, idx});
          end
        end
        default: begin
          if (slot_end) begin
            state <= BLANK;
            presc <= '0;
            idx   <= idx_nxt;
            an0   <= 4'h0;
            an1   <= 4'h0;
            seg0  <= digit_seg(disp_nxt, disp_dp_nxt, {1'b0, idx_nxt});
            seg1  <= digit_seg(disp_nxt, disp_dp_nxt, {1'b1, idx_nxt});
          end else begin
            presc <= presc + PW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
// Directed bench for led_scan_driver with SCAN_DIV=8, BLANK_CYC=2 (frame = 32 cycles).
// cyc counts cycles since reset release; cyc % 32 is the position in the frame.

module tb_led_scan_driver;

`ifdef LED_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, wr_en;
  logic [31:0] num_i;
  logic [7:0]  dp_i;
  logic        busy;
  logic [7:0]  seg0, seg1;
  logic [3:0]  an0, an1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  led_scan_driver #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .num_i(num_i), .dp_i(dp_i),
    .busy(busy), .seg0(seg0), .an0(an0), .seg1(seg1), .an1(an1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int p);
    while ((cyc % 32) != p) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] z;
    z = LZB ? 8'h00 : 8'h3F;

    rst = 1'b1; en = 1'b1; wr_en = 1'b0; num_i = 32'h0; dp_i = 8'h0;
    tick(); tick(); tick();
    check("rst_seg0", seg0, 8'h00);
    check("rst_seg1", seg1, 8'h00);
    check("rst_an0", an0, 4'h0);
    check("rst_an1", an1, 4'h0);
    check("rst_busy", busy, 1'b0);

    rst = 1'b0; cyc = 0;
    check("c0_an0", an0, 4'h0);
    tick();
    check("c1_an0", an0, 4'h0);
    tick();
    check("c2_an0", an0, 4'b0001);
    check("c2_an1", an1, 4'b0001);
    check("c2_seg0", seg0, 8'h3F);
    check("c2_seg1", seg1, z);
    go(7);
    check("c7_an0", an0, 4'b0001);
    go(8);
    check("c8_an0", an0, 4'h0);
    go(9);
    check("c9_an0", an0, 4'h0);
    go(10);
    check("c10_an0", an0, 4'b0010);

    // write mid-frame, pending until the boundary
    wr_en = 1'b1; num_i = 32'h1234_ABCD; dp_i = 8'h00;
    tick();
    wr_en = 1'b0;
    check("wr_busy", busy, 1'b1);
    check("wr_hold_seg0", seg0, 8'h3F);
    go(31);
    check("wr_busy_b4_bnd", busy, 1'b1);
    tick();
    check("wr_busy_clr", busy, 1'b0);

    // frame 1: value 1234_ABCD on display
    go(2);
    check("f1_d0_seg0", seg0, 8'h5E);
    check("f1_d0_seg1", seg1, 8'h66);
    check("f1_d0_an0", an0, 4'b0001);
    go(3);
    wr_en = 1'b1; num_i = 32'h0000_0001;
    tick();
    wr_en = 1'b0;
    go(10);
    check("f1_d1_seg0", seg0, 8'h39);
    check("f1_d1_seg1", seg1, 8'h4F);
    go(12);
    wr_en = 1'b1; num_i = 32'h0000_0002;
    tick();
    wr_en = 1'b0;
    go(26);
    check("f1_d3_seg0", seg0, 8'h77);
    check("f1_d3_seg1", seg1, 8'h06);
    check("f1_d3_an0", an0, 4'b1000);
    check("f1_busy", busy, 1'b1);
    go(31);
    tick();

    // frame 2: last write wins
    go(2);
    check("f2_d0_seg0", seg0, 8'h5B);
    check("f2_d4_seg1", seg1, z);
    go(10);
    check("f2_d1_seg0", seg0, z);
    go(31);

    // write on the boundary cycle goes straight to disp
    wr_en = 1'b1; num_i = 32'h0000_0050; dp_i = 8'h04;
    tick();
    wr_en = 1'b0;
    check("bnd_busy", busy, 1'b0);
    go(2);
    check("f3_d0_seg0", seg0, 8'h3F);
    check("f3_d4_seg1", seg1, z);
    go(10);
    check("f3_d1_seg0", seg0, 8'h6D);
    check("f3_d5_seg1", seg1, z);
    go(18);
    check("f3_d2_seg0", seg0, LZB ? 8'h80 : 8'hBF);
    check("f3_d6_seg1", seg1, z);
    check("f3_d2_an0", an0, 4'b0100);
    go(26);
    check("f3_d3_seg0", seg0, z);
    check("f3_d7_seg1", seg1, z);
    go(31);
    tick();

    // en low for a whole frame
    en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check("dis_an0", an0, 4'h0);
      check("dis_an1", an1, 4'h0);
      tick();
    end
    go(9);
    en = 1'b1;
    tick();
    check("en_an0", an0, 4'b0010);
    check("en_an1", an1, 4'b0010);
    check("en_seg0", seg0, 8'h6D);

    // reset mid-frame
    go(20);
    rst = 1'b1;
    tick();
    check("mrst_an0", an0, 4'h0);
    check("mrst_seg0", seg0, 8'h00);
    check("mrst_seg1", seg1, 8'h00);
    check("mrst_busy", busy, 1'b0);
    rst = 1'b0; cyc = 0;
    tick(); tick();
    check("mrst_c2_an0", an0, 4'b0001);
    check("mrst_c2_seg0", seg0, 8'h3F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
